commit_buffer: RTL

- In-order retirement buffer (reorder buffer) for the out-of-order core; DEPTH-entry circular queue indexed by commit_id.
- Dispatch allocates a commit_id per instruction. Execution units return packed Result messages on a Message receiver port (en/reject/msg).
- Entries retire strictly in allocation order as register writebacks (CommitInfo fields) or branch resolutions (BranchResult fields).
- A retiring mispredicted branch flushes every younger entry.

---
 rtl/commit_buffer.sv | 89 ++++++++
 1 files changed

// File: rtl/commit_buffer.sv
// commit_buffer: in-order retirement buffer; results land out of order, entries retire from the head.
module commit_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_en,
  output logic        alloc_reject,
  output logic [7:0]  alloc_id,
  input  logic        result_en,
  output logic        result_reject,
  input  logic [56:0] result_msg,
  output logic        commit_en,
  output logic [7:0]  commit_dest_logic,
  output logic [31:0] commit_data,
  output logic        branch_en,
  output logic        branch_miss,
  output logic        branch_taken,
  output logic [15:0] branch_new_pc,
  output logic        flush
);
  localparam int P = $clog2(DEPTH);
  logic [P:0] head, tail;
  logic [P-1:0] hi, ti, ri;
  logic [DEPTH-1:0] alloc, done, kind;
  logic [47:0] pay [DEPTH];
  logic full, empty, retire, pop_miss, hit;
  assign hi = head[P-1:0];
  assign ti = tail[P-1:0];
  assign ri = result_msg[49 +: P];
  assign empty = head == tail;
  assign full = (head[P] != tail[P]) && (hi == ti);
  assign retire = !empty && alloc[hi] && done[hi];
  assign pop_miss = retire && kind[hi] && pay[hi][47];
  // ids beyond DEPTH never address a live entry
  assign hit = result_en && !reset && ((result_msg[56:49] >> P) == 8'd0) && alloc[ri];
  assign alloc_reject = full || pop_miss || reset;
  assign alloc_id = 8'(ti);
  assign result_reject = reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      alloc <= '0;
      done <= '0;
      commit_en <= 1'b0;
      commit_dest_logic <= '0;
      commit_data <= '0;
      branch_en <= 1'b0;
      branch_miss <= 1'b0;
      branch_taken <= 1'b0;
      branch_new_pc <= '0;
      flush <= 1'b0;
    end else begin
      commit_en <= retire && !kind[hi];
      branch_en <= retire && kind[hi];
      flush <= pop_miss;
      if (retire && !kind[hi]) begin
        commit_dest_logic <= pay[hi][39:32];
        commit_data <= pay[hi][31:0];
      end
      if (retire && kind[hi]) begin
        branch_miss <= pay[hi][47];
        branch_taken <= pay[hi][46];
        branch_new_pc <= pay[hi][45:30];
      end
      if (hit && !pop_miss) begin
        kind[ri] <= result_msg[48];
        pay[ri] <= result_msg[47:0];
        done[ri] <= 1'b1;
      end
      // retirement clears after the result write so a same-edge result to the popped head is lost
      if (retire) begin
        alloc[hi] <= 1'b0;
        done[hi] <= 1'b0;
        head <= head + 1'b1;
      end
      if (pop_miss) begin
        alloc <= '0;
        done <= '0;
        tail <= head + 1'b1;
      end else if (alloc_en && !alloc_reject) begin
        alloc[ti] <= 1'b1;
        done[ti] <= 1'b0;
        tail <= tail + 1'b1;
      end
    end
  end
endmodule
